// File: rtl/uart_mem_loader_pkg.sv
// Shared constants for the serial program loader: framing bytes, reply codes,
// FSM state encodings and the captured frame header.
package uart_mem_loader_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_BYTE     = 8'h06;
    localparam logic [7:0] NAK_BYTE     = 8'h15;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_HDR       = 4'd1;
    localparam logic [3:0] S_WAIT_HELD = 4'd2;
    localparam logic [3:0] S_DATA_HI   = 4'd3;
    localparam logic [3:0] S_DATA_LO   = 4'd4;
    localparam logic [3:0] S_WRITE     = 4'd5;
    localparam logic [3:0] S_CHK       = 4'd6;
    localparam logic [3:0] S_REPLY     = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    typedef struct packed {
        logic [15:0] org;
        logic [15:0] cnt;
    } hdr_t;

    // States in which the inter-byte inactivity timer runs.
    function automatic logic in_frame(input logic [3:0] s);
        return (s == S_HDR) || (s == S_WAIT_HELD) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_WRITE) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/uart_mem_loader_inactivity_timer.sv
// Idle-cycle counter: clears on activity or when disabled, flags expiry after
// LIMIT consecutive enabled idle cycles.
module inactivity_timer #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    assign expired = en && (count == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr || !en)
            count <= '0;
        else if (!expired)
            count <= count + W'(1);
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Serial program loader: halts the CPU, writes a framed word stream into memory
// and answers ACK/NAK; a good frame hands the CPU its start PC.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Done,
    output logic        o_Cpu_Hold,
    input  logic        i_Cpu_Held,
    output logic        o_Mem_Own,
    output logic        o_Mem_EN,
    output logic        o_Mem_WE,
    output logic [15:0] o_Mem_Addr,
    output logic [15:0] o_Mem_Data,
    output logic [15:0] o_Start_PC,
    output logic        o_Start_Valid,
    output logic        o_Busy,
    output logic        o_Err
);

    logic [3:0]  state;
    hdr_t        hdr;
    logic [1:0]  hdr_idx;
    logic [7:0]  sum;
    logic [15:0] addr;
    logic [15:0] remaining;
    logic [7:0]  d_hi;
    logic [7:0]  d_lo;
    logic        ok;
    logic        tx_sent;
    logic        timed;
    logic        expired;
    logic        abort;
    logic [7:0]  sum_next;

    assign timed    = in_frame(state);
    assign sum_next = sum + i_Rx_Byte;
    // A byte while waiting for the CPU or during the write cycle has nowhere to go.
    assign abort    = timed && (expired ||
                      (i_Rx_DV && (state == S_WAIT_HELD || state == S_WRITE)));

    inactivity_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (i_Clk),
        .rst_n   (i_Rst_n),
        .en      (timed),
        .clr     (i_Rx_DV),
        .expired (expired)
    );

    assign o_Busy     = (state != S_IDLE);
    assign o_Mem_EN   = (state == S_WRITE);
    assign o_Mem_WE   = (state == S_WRITE);
    assign o_Mem_Addr = o_Mem_EN ? addr : 16'h0000;
    assign o_Mem_Data = o_Mem_EN ? {d_hi, d_lo} : 16'h0000;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= S_IDLE;
            hdr           <= '0;
            hdr_idx       <= '0;
            sum           <= '0;
            addr          <= '0;
            remaining     <= '0;
            d_hi          <= '0;
            d_lo          <= '0;
            ok            <= 1'b0;
            tx_sent       <= 1'b0;
            o_Tx_DV       <= 1'b0;
            o_Tx_Byte     <= '0;
            o_Cpu_Hold    <= 1'b0;
            o_Mem_Own     <= 1'b0;
            o_Start_PC    <= '0;
            o_Start_Valid <= 1'b0;
            o_Err         <= 1'b0;
        end else begin
            o_Tx_DV       <= 1'b0;
            o_Start_Valid <= 1'b0;
            if (abort) begin
                state   <= S_REPLY;
                ok      <= 1'b0;
                tx_sent <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                        state      <= S_HDR;
                        o_Cpu_Hold <= 1'b1;
                        o_Err      <= 1'b0;
                        sum        <= '0;
                        hdr_idx    <= '0;
                    end
                    S_HDR: if (i_Rx_DV) begin
                        sum     <= sum_next;
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0: hdr.org[15:8] <= i_Rx_Byte;
                            2'd1: hdr.org[7:0]  <= i_Rx_Byte;
                            2'd2: hdr.cnt[15:8] <= i_Rx_Byte;
                            default: begin
                                hdr.cnt[7:0] <= i_Rx_Byte;
                                state        <= S_WAIT_HELD;
                            end
                        endcase
                    end
                    S_WAIT_HELD: if (i_Cpu_Held) begin
                        o_Mem_Own <= 1'b1;
                        addr      <= hdr.org;
                        remaining <= hdr.cnt;
                        state     <= (hdr.cnt == 16'h0000) ? S_CHK : S_DATA_HI;
                    end
                    S_DATA_HI: if (i_Rx_DV) begin
                        d_hi  <= i_Rx_Byte;
                        sum   <= sum_next;
                        state <= S_DATA_LO;
                    end
                    S_DATA_LO: if (i_Rx_DV) begin
                        d_lo  <= i_Rx_Byte;
                        sum   <= sum_next;
                        state <= S_WRITE;
                    end
                    S_WRITE: begin
                        addr      <= addr + 16'd1;
                        remaining <= remaining - 16'd1;
                        state     <= (remaining == 16'd1) ? S_CHK : S_DATA_HI;
                    end
                    S_CHK: if (i_Rx_DV) begin
                        ok      <= (sum_next == 8'h00);
                        sum     <= sum_next;
                        tx_sent <= 1'b0;
                        state   <= S_REPLY;
                    end
                    S_REPLY: begin
                        if (!tx_sent) begin
                            o_Tx_DV   <= 1'b1;
                            o_Tx_Byte <= ok ? ACK_BYTE : NAK_BYTE;
                            tx_sent   <= 1'b1;
                        end else if (i_Tx_Done) begin
                            // Release happens on DONE entry so the CPU resumes one cycle after TX completes.
                            state      <= S_DONE;
                            o_Cpu_Hold <= 1'b0;
                            o_Mem_Own  <= 1'b0;
                            if (ok) begin
                                o_Start_PC    <= hdr.org;
                                o_Start_Valid <= 1'b1;
                            end else begin
                                o_Err <= 1'b1;
                            end
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: expected writes, replies and start PCs
// are queued as frames are driven and popped when the loader produces them.
module tb_uart_mem_loader;

    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_done = 1'b0;
    logic        cpu_hold;
    logic        cpu_held = 1'b0;
    logic        mem_own, mem_en, mem_we, start_valid, busy, err;
    logic [15:0] mem_addr, mem_data, start_pc;

    int errors = 0;
    int checks = 0;
    int held_delay = 3;

    logic [31:0] wr_q[$];
    logic [7:0]  tx_q[$];
    logic [15:0] pc_q[$];
    logic [15:0] words[$];

    always #5 clk = ~clk;

    uart_mem_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
        .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Done(tx_done),
        .o_Cpu_Hold(cpu_hold), .i_Cpu_Held(cpu_held), .o_Mem_Own(mem_own),
        .o_Mem_EN(mem_en), .o_Mem_WE(mem_we), .o_Mem_Addr(mem_addr),
        .o_Mem_Data(mem_data), .o_Start_PC(start_pc), .o_Start_Valid(start_valid),
        .o_Busy(busy), .o_Err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every loader event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                check("wr_own", {31'd0, mem_own}, 1);
                check("wr_en", {31'd0, mem_en}, 1);
                check("wr_expected", {31'd0, wr_q.size() > 0}, 1);
                if (wr_q.size() > 0) check("wr_addr_data", {mem_addr, mem_data}, wr_q.pop_front());
            end
            if (tx_dv) begin
                check("tx_expected", {31'd0, tx_q.size() > 0}, 1);
                if (tx_q.size() > 0) check("tx_byte", {24'd0, tx_byte}, {24'd0, tx_q.pop_front()});
            end
            if (start_valid) begin
                check("pc_expected", {31'd0, pc_q.size() > 0}, 1);
                if (pc_q.size() > 0) check("start_pc", {16'd0, start_pc}, {16'd0, pc_q.pop_front()});
            end
        end
    end

    // UART TX model: completion a few cycles after each request.
    initial forever begin
        @(posedge clk); #1;
        if (tx_dv) begin
            repeat (4) @(posedge clk);
            #1;
            check("hold_before_done", {31'd0, cpu_hold}, 1);
            tx_done = 1'b1;
            @(posedge clk); #1;
            tx_done = 1'b0;
            check("hold_after_done", {31'd0, cpu_hold}, 0);
            check("busy_in_done", {31'd0, busy}, 1);
        end
    end

    // CPU model: acknowledges the hold after held_delay cycles.
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (cpu_hold) begin
                if (n >= held_delay) cpu_held = 1'b1;
                n++;
            end else begin
                n = 0;
                cpu_held = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    task automatic wait_own(input string tag);
        for (int i = 0; i < 400 && !mem_own; i++) begin
            @(posedge clk); #1;
        end
        check(tag, {31'd0, mem_own}, 1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int i = 0; i < bound && busy; i++) begin
            @(posedge clk); #1;
        end
        check(tag, {31'd0, busy}, 0);
    endtask

    task automatic send_header(input logic [15:0] org, input logic [15:0] cnt, output logic [7:0] s);
        send_byte(8'hA5);
        check("hold_on_sync", {31'd0, cpu_hold}, 1);
        check("err_clr_on_sync", {31'd0, err}, 0);
        send_byte(org[15:8]); send_byte(org[7:0]);
        send_byte(cnt[15:8]); send_byte(cnt[7:0]);
        s = org[15:8] + org[7:0] + cnt[15:8] + cnt[7:0];
        check("own_after_hdr", {31'd0, mem_own}, 0);
    endtask

    // Drives a whole frame using the words queue; delta != 0 spoils the checksum.
    task automatic send_frame(input logic [15:0] org, input logic [7:0] delta, input logic reply_junk);
        logic [7:0]  s;
        logic [15:0] a;
        logic        good;
        good = (delta == 8'h00);
        send_header(org, 16'(words.size()), s);
        wait_own("own_granted");
        a = org;
        foreach (words[i]) begin
            send_byte(words[i][15:8]);
            wr_q.push_back({a, words[i]});
            send_byte(words[i][7:0]);
            s = s + words[i][15:8] + words[i][7:0];
            a = a + 16'd1;
        end
        tx_q.push_back(good ? 8'h06 : 8'h15);
        if (good) pc_q.push_back(org);
        send_byte(8'h00 - s + delta);
        if (reply_junk) send_byte(8'hA5);
        wait_idle("frame_idle", 200);
        check("err_after_frame", {31'd0, err}, {31'd0, !good});
    endtask

    initial begin
        logic [7:0] s;
        #1;
        check("rst_outs_a", {tx_dv, tx_byte, cpu_hold, mem_own, mem_en, mem_we, mem_addr}, 0);
        check("rst_outs_b", {mem_data, start_pc}, 0);
        check("rst_outs_c", {29'd0, start_valid, busy, err}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send_byte(8'h11);
        check("idle_discard", {31'd0, busy}, 0);

        words = '{16'h1234, 16'hABCD};
        send_frame(16'h3000, 8'h00, 1'b1);
        send_frame(16'h3000, 8'h01, 1'b0);
        words = '{};
        send_frame(16'h3100, 8'h00, 1'b0);
        words = '{16'hA5A5, 16'h0102};
        send_frame(16'hFFFF, 8'h00, 1'b0);

        held_delay = 100;
        words = '{16'h5555, 16'h00FF};
        send_frame(16'h4000, 8'h00, 1'b0);
        send_header(16'h4100, 16'h0001, s);
        tx_q.push_back(8'h15);
        send_byte(8'h42);
        wait_idle("held_abort_idle", 200);
        check("held_abort_err", {31'd0, err}, 1);

        held_delay = 3;
        send_header(16'h4200, 16'h0002, s);
        wait_own("tmo_own");
        tx_q.push_back(8'h15);
        send_byte(8'h77);
        wait_idle("tmo_idle", TMO + 200);
        check("tmo_err", {31'd0, err}, 1);

        send_byte(8'hA5);
        send_byte(8'h30);
        check("pre_rst_hold", {31'd0, cpu_hold}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a", {tx_dv, tx_byte, cpu_hold, mem_own, mem_en, mem_we, mem_addr}, 0);
        check("mid_rst_b", {mem_data, start_pc}, 0);
        check("mid_rst_c", {29'd0, start_valid, busy, err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        words = '{16'hBEEF, 16'h0000};
        send_frame(16'h5000, 8'h00, 1'b0);

        repeat (5) @(posedge clk);
        check("wr_q_drained", wr_q.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);
        check("pc_q_drained", pc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
